// File: rtl/piece_bag_rng.sv
// Tetromino source: a Fibonacci LFSR feeds a uniform or 7-bag sampler that fills
// a short FIFO, exposed as a head piece plus a preview window.
module piece_bag_rng #(
  parameter int                    LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS          = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED          = 16'hACE1,
  parameter int                    NUM_PIECES    = 7,
  parameter int                    PREVIEW_DEPTH = 3,
  parameter bit                    BAG_MODE      = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seed_load,
  input  logic [LFSR_WIDTH-1:0]      seed_in,
  input  logic                       req,
  output logic [2:0]                 piece,
  output logic                       piece_valid,
  output logic [3*PREVIEW_DEPTH-1:0] preview,
  output logic [PREVIEW_DEPTH-1:0]   preview_valid,
  output logic [NUM_PIECES-1:0]      bag_mask
);

  localparam int              QD   = PREVIEW_DEPTH + 1;
  localparam int              CW   = $clog2(QD + 1);
  localparam logic [CW-1:0]   QD_C = CW'(QD);
  localparam logic [3:0]      NP_C = 4'(NUM_PIECES);

  typedef enum logic {FILL, FULL} fill_state_t;

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [2:0]            q   [QD];
  logic [2:0]            q_n [QD];
  logic [QD-1:0]         valid, valid_n;
  logic [CW-1:0]         count, count_n, slot;
  logic [NUM_PIECES-1:0] mask_n, cleared;
  logic [2:0]            cand;
  logic                  feedback, cand_free, accept, pop, push;
  fill_state_t           state;

  assign state    = (count == QD_C) ? FULL : FILL;
  assign cand     = lfsr[LFSR_WIDTH-1 -: 3];
  assign feedback = ^(lfsr & TAPS);

  always_comb begin
    // NOTE: every variable is given a default before any branch, so no latch is inferred.
    cand_free = 1'b0;
    cleared   = bag_mask;
    for (int i = 0; i < NUM_PIECES; i++) begin
      if (cand == 3'(i)) begin
        cand_free  = bag_mask[i];
        cleared[i] = 1'b0;
      end
    end

    // Out-of-range codes are dropped rather than folded, keeping the draw unbiased.
    accept = ({1'b0, cand} < NP_C) && (!BAG_MODE || cand_free);
    pop    = req && valid[0];
    push   = accept && ((state == FILL) || pop);
    slot   = pop ? count - CW'(1) : count;

    for (int i = 0; i < QD; i++) q_n[i] = q[i];
    if (pop) begin
      for (int i = 0; i < QD - 1; i++) q_n[i] = q[i + 1];
      q_n[QD-1] = 3'd0;
    end
    if (push) begin
      for (int i = 0; i < QD; i++) begin
        if (slot == CW'(i)) q_n[i] = cand;
      end
    end

    count_n = count;
    if (push && !pop)      count_n = count + CW'(1);
    else if (pop && !push) count_n = count - CW'(1);

    for (int i = 0; i < QD; i++) valid_n[i] = (CW'(i) < count_n);

    // An emptied bag refills on the same edge, so the mask is never seen all-zero.
    mask_n = bag_mask;
    if (BAG_MODE && push) mask_n = (cleared == '0) ? '1 : cleared;
  end

  // NOTE: the queue slots are reset as well, because invalid entries must read 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr     <= SEED;
      count    <= '0;
      valid    <= '0;
      bag_mask <= '1;
      for (int i = 0; i < QD; i++) q[i] <= 3'd0;
    end else if (seed_load) begin
      lfsr     <= (seed_in == '0) ? SEED : seed_in;
      count    <= '0;
      valid    <= '0;
      bag_mask <= '1;
      for (int i = 0; i < QD; i++) q[i] <= 3'd0;
    end else begin
      // NOTE: non-blocking updates, so every register samples pre-edge values.
      lfsr     <= {lfsr[LFSR_WIDTH-2:0], feedback};
      count    <= count_n;
      valid    <= valid_n;
      bag_mask <= mask_n;
      for (int i = 0; i < QD; i++) q[i] <= q_n[i];
    end
  end

  assign piece         = q[0];
  assign piece_valid   = valid[0];
  assign preview_valid = valid[QD-1:1];

  for (genvar k = 0; k < PREVIEW_DEPTH; k++) begin : g_preview
    assign preview[3*k +: 3] = q[k + 1];
  end

endmodule
